// File: rtl/spart_driver.sv
// CPU stand-in for the SPART bus port: programs the baud divisor, then echoes every received byte.
// Optional BAUD_RECONFIG_EN: a br_cfg change seen in WAIT_RX reprograms the divisor.
//
// state   | meaning
// CFG_LO  | write divisor low byte (ioaddr 10)
// CFG_HI  | write divisor high byte (ioaddr 11), raise cfg_done
// WAIT_RX | idle until rda
// RD_RX   | read received byte (ioaddr 00)
// WAIT_TX | idle until tbr
// WR_TX   | write byte back (ioaddr 00), count it
module spart_driver #(
    parameter int CLK_HZ = 50_000_000,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       br_cfg,
    input  logic             rda,
    input  logic             tbr,
    output logic             iocs,
    output logic             iorw,
    output logic [1:0]       ioaddr,
    inout  wire  [7:0]       databus,
    output logic             cfg_done,
    output logic [CNT_W-1:0] char_cnt
);

    typedef enum logic [2:0] {
        CFG_LO  = 3'd0,
        CFG_HI  = 3'd1,
        WAIT_RX = 3'd2,
        RD_RX   = 3'd3,
        WAIT_TX = 3'd4,
        WR_TX   = 3'd5
    } state_t;

    function automatic logic [15:0] div_of(input logic [1:0] br);
        int unsigned baud;
        baud = 32'd4800 << br;
        return 16'(32'(CLK_HZ) / (32'd16 * baud) - 32'd1);
    endfunction

    state_t           state_q, state_d;
    logic [1:0]       br_q, br_d;
    logic             cfg_done_q, cfg_done_d;
    logic [7:0]       rx_q, rx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             iocs_dec, iorw_dec;
    logic [1:0]       addr_dec;
    logic [7:0]       data_dec;
    logic [15:0]      div_in, div_held;
    logic             bus_oe;

    assign div_in   = div_of(br_cfg);
    assign div_held = div_of(br_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CFG_LO;
            br_q       <= 2'b00;
            cfg_done_q <= 1'b0;
            rx_q       <= 8'h00;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            br_q       <= br_d;
            cfg_done_q <= cfg_done_d;
            rx_q       <= rx_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        br_d       = br_q;
        cfg_done_d = cfg_done_q;
        rx_d       = rx_q;
        cnt_d      = cnt_q;
        iocs_dec   = 1'b0;
        iorw_dec   = 1'b1;
        addr_dec   = 2'b00;
        data_dec   = 8'h00;
        case (state_q)
            CFG_LO: begin
                iocs_dec = 1'b1;
                iorw_dec = 1'b0;
                addr_dec = 2'b10;
                data_dec = div_in[7:0];
                br_d     = br_cfg;
                state_d  = CFG_HI;
            end
            CFG_HI: begin
                iocs_dec   = 1'b1;
                iorw_dec   = 1'b0;
                addr_dec   = 2'b11;
                data_dec   = div_held[15:8];
                cfg_done_d = 1'b1;
                state_d    = WAIT_RX;
            end
            WAIT_RX: begin
`ifdef BAUD_RECONFIG_EN
                // a pending rda stays high and is picked up once the new divisor is written
                if (br_cfg != br_q) begin
                    state_d    = CFG_LO;
                    cfg_done_d = 1'b0;
                end else
`endif
                if (rda) state_d = RD_RX;
            end
            RD_RX: begin
                iocs_dec = 1'b1;
                iorw_dec = 1'b1;
                rx_d     = databus;
                state_d  = WAIT_TX;
            end
            WAIT_TX: begin
                if (tbr) state_d = WR_TX;
            end
            WR_TX: begin
                iocs_dec = 1'b1;
                iorw_dec = 1'b0;
                data_dec = rx_q;
                cnt_d    = cnt_q + CNT_W'(1);
                state_d  = WAIT_RX;
            end
            default: state_d = CFG_LO;
        endcase
    end

    // reset masks the CFG_LO decode so the bus is released within the reset cycle
    assign iocs     = iocs_dec & ~rst;
    assign iorw     = iorw_dec | rst;
    assign ioaddr   = addr_dec;
    assign bus_oe   = iocs_dec & ~iorw_dec & ~rst;
    assign databus  = bus_oe ? data_dec : 8'hzz;
    assign cfg_done = cfg_done_q;
    assign char_cnt = cnt_q;

endmodule

// File: tb/tb_spart_driver.sv
// Randomized echo bench for spart_driver: a SPART model feeds bytes, a monitor logs every bus access.
// Build with +define+BAUD_RECONFIG_EN to exercise the reconfiguration path.
module tb_spart_driver;

    localparam int CLK_HZ = 50_000_000;
    localparam int CNT_W  = 8;

    typedef struct packed {
        logic       rw;
        logic [1:0] addr;
        logic [7:0] data;
    } acc_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       br_cfg = 2'b01;
    logic             rda;
    logic             tbr = 1'b0;
    logic             iocs, iorw;
    logic [1:0]       ioaddr;
    wire  [7:0]       databus;
    logic             cfg_done;
    logic [CNT_W-1:0] char_cnt;

    logic [7:0] rx_data = 8'h00;
    int         rx_pushed = 0;
    int         rx_taken = 0;
    int         exp_cnt = 0;
    int         n_vec = 0;
    int         n_err = 0;
    acc_t       acc_q[$];

    spart_driver #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .br_cfg   (br_cfg),
        .rda      (rda),
        .tbr      (tbr),
        .iocs     (iocs),
        .iorw     (iorw),
        .ioaddr   (ioaddr),
        .databus  (databus),
        .cfg_done (cfg_done),
        .char_cnt (char_cnt)
    );

    always #5 clk = ~clk;

    // SPART side: answers reads, parks 0x5A on an unselected bus so a stray DUT drive shows up
    assign databus = (iocs && iorw) ? rx_data : (!iocs ? 8'h5A : 8'hzz);
    assign rda     = (rx_pushed != rx_taken);

    always @(posedge clk)
        if (!rst && iocs && iorw && ioaddr == 2'b00) rx_taken <= rx_taken + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (iocs) begin
                acc_t a;
                a.rw   = iorw;
                a.addr = ioaddr;
                a.data = databus;
                acc_q.push_back(a);
            end else begin
                chk("idle_bus", {21'd0, iorw, ioaddr, databus}, {21'd0, 1'b1, 2'b00, 8'h5A});
            end
        end
    end

    function automatic logic [15:0] div_model(input logic [1:0] br);
        int baud;
        baud = 4800 * (1 << br);
        return 16'(CLK_HZ / (16 * baud) - 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_acc(input string tag, input acc_t e);
        logic [31:0] got;
        if (acc_q.size() == 0) got = 32'hFFFF_FFFF;
        else                   got = {21'd0, acc_q.pop_front()};
        chk(tag, got, {21'd0, e});
    endtask

    task automatic wait_acc(input int n, input int limit, output int t);
        t = 0;
        while (acc_q.size() < n && t < limit) begin
            tick();
            t++;
        end
    endtask

    task automatic expect_cfg(input logic [1:0] br);
        logic [15:0] d;
        d = div_model(br);
        expect_acc("cfg_lo", {1'b0, 2'b10, d[7:0]});
        expect_acc("cfg_hi", {1'b0, 2'b11, d[15:8]});
    endtask

    task automatic do_reset(input logic [1:0] br);
        rst    = 1'b1;
        br_cfg = br;
        tbr    = 1'b0;
        tick();
        tick();
        chk("rst_iocs", {31'd0, iocs}, 32'd0);
        chk("rst_iorw", {31'd0, iorw}, 32'd1);
        chk("rst_bus", {24'd0, databus}, 32'h5A);
        chk("rst_cnt", {24'd0, char_cnt}, 32'd0);
        chk("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
        acc_q.delete();
        rx_pushed = rx_taken;
        exp_cnt   = 0;
        rst = 1'b0;
        tick();
        chk("cfg_done_early", {31'd0, cfg_done}, 32'd0);
        tick();
        chk("cfg_done", {31'd0, cfg_done}, 32'd1);
        expect_cfg(br);
        chk("cfg_extra", acc_q.size(), 32'd0);
    endtask

    task automatic echo(input logic [7:0] b, input int dly);
        int t;
        int t2;
        tbr     = (dly == 0);
        rx_data = b;
        rx_pushed++;
        wait_acc(1, 20, t);
        expect_acc("echo_rd", {1'b1, 2'b00, b});
        if (dly > 0) begin
            repeat (dly) tick();
            chk("no_early_wr", acc_q.size(), 32'd0);
            tbr = 1'b1;
            wait_acc(1, 20, t2);
            chk("wr_after_tbr", t2, 32'd2);
        end else begin
            wait_acc(1, 20, t2);
            chk("echo_lat", t + t2 - 1, 32'd3);
        end
        expect_acc("echo_wr", {1'b0, 2'b00, b});
        tbr = 1'b0;
        exp_cnt++;
        chk("char_cnt", {24'd0, char_cnt}, exp_cnt % (1 << CNT_W));
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        logic [7:0] b;

        do_reset(2'b01);
        echo(8'h41, 0);
        echo(8'($urandom), 100);
        for (int i = 0; i < 6; i++) echo(8'($urandom), int'($urandom_range(0, 4)));

        // reset landing inside the WR_TX cycle
        tbr     = 1'b0;
        rx_data = 8'($urandom);
        rx_pushed++;
        wait_acc(1, 20, t);
        acc_q.delete();
        tbr = 1'b1;
        tick();
        rst = 1'b1;
        #1;
        chk("rst_mid_iocs", {31'd0, iocs}, 32'd0);
        chk("rst_mid_bus", {24'd0, databus}, 32'h5A);
        chk("rst_mid_cnt", {24'd0, char_cnt}, 32'd0);
        do_reset(2'b00);

        for (int i = 0; i < 256; i++) echo(8'($urandom), int'($urandom_range(0, 3)));
        chk("cnt_wrap", {24'd0, char_cnt}, 32'd0);

        do_reset(2'b01);
        echo(8'($urandom), 0);
        b       = 8'($urandom);
        br_cfg  = 2'b11;
        tbr     = 1'b1;
        rx_data = b;
        rx_pushed++;
`ifdef BAUD_RECONFIG_EN
        tick();
        chk("reconf_cfg_done", {31'd0, cfg_done}, 32'd0);
        wait_acc(4, 30, t);
        expect_cfg(2'b11);
`else
        wait_acc(2, 30, t);
`endif
        expect_acc("pend_rd", {1'b1, 2'b00, b});
        expect_acc("pend_wr", {1'b0, 2'b00, b});
        exp_cnt++;
        chk("pend_cnt", {24'd0, char_cnt}, exp_cnt % (1 << CNT_W));
        chk("pend_cfg_done", {31'd0, cfg_done}, 32'd1);
        tbr = 1'b0;
        repeat (3) tick();
        chk("tail_extra", acc_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
